// File: rtl/instruction_reg_param.sv
// JTAG instruction register: WIDTH-bit shift/capture stage, update stage,
// one-hot instruction decode and a shift-length monitor. All state is on TCK
// (clk); Test_Log_Res clears everything asynchronously to the BYPASS state.
module instruction_reg_param #(
  parameter int unsigned      WIDTH        = 4,
  parameter logic [WIDTH-1:0] RESET_OPCODE = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] OPC_EXTEST   = WIDTH'(0),
  parameter logic [WIDTH-1:0] OPC_SAMPLE   = WIDTH'(1),
  parameter logic [WIDTH-1:0] OPC_IDCODE   = WIDTH'(2),
  parameter logic [WIDTH-1:0] OPC_BYPASS   = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             Test_Log_Res,
  input  logic             Shift_in,
  output logic             Shift_out,
  input  logic             Capture_IR,
  input  logic             Shift_IR,
  input  logic             Update_IR,
  input  logic [WIDTH-3:0] Par_in,
  output logic [WIDTH-1:0] Par_out,
  output logic             Sel_extest,
  output logic             Sel_sample,
  output logic             Sel_idcode,
  output logic             Sel_bypass,
  output logic             Short_shift
);

  // Counter must be able to hold WIDTH itself: saturation marks a full shift.
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);

  // 1149.1 requires the two LSBs captured into the IR to be 2'b01; the same
  // pattern is the reset value so TDO is well defined straight out of reset.
  localparam logic [WIDTH-1:0] STAGE_RST = {{(WIDTH-2){1'b0}}, 2'b01};

  logic [WIDTH-1:0] stage_q, stage_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] par_q, par_d;
  logic             short_q, short_d;

  // Shift stage next state: capture beats shift, otherwise hold.
  always_comb begin
    stage_d = stage_q;
    cnt_d   = cnt_q;
    if (Capture_IR) begin
      stage_d = {Par_in, 2'b01};
      cnt_d   = '0;
    end else if (Shift_IR) begin
      stage_d = {Shift_in, stage_q[WIDTH-1:1]};
      if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1);
    end
  end

  // Update stage next state; samples the pre-edge stage and counter so a
  // concurrent capture/shift cannot leak into the new instruction.
  always_comb begin
    par_d   = par_q;
    short_d = short_q;
    if (Update_IR) begin
      par_d   = stage_q;
      short_d = (cnt_q < CNT_FULL);
    end
  end

  // All registers, asynchronously forced to the BYPASS/reset state.
  always_ff @(posedge clk or posedge Test_Log_Res) begin
    if (Test_Log_Res) begin
      stage_q <= STAGE_RST;
      cnt_q   <= '0;
      par_q   <= RESET_OPCODE;
      short_q <= 1'b0;
    end else begin
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      short_q <= short_d;
    end
  end

  // One-hot decode of the current instruction; anything unassigned is BYPASS.
  always_comb begin
    Sel_extest = 1'b0;
    Sel_sample = 1'b0;
    Sel_idcode = 1'b0;
    Sel_bypass = 1'b0;
    if (par_q == OPC_EXTEST)      Sel_extest = 1'b1;
    else if (par_q == OPC_SAMPLE) Sel_sample = 1'b1;
    else if (par_q == OPC_IDCODE) Sel_idcode = 1'b1;
    else                          Sel_bypass = 1'b1;
  end

  // TDO comes straight off the stage LSB; no retiming flop here.
  assign Shift_out   = stage_q[0];
  assign Par_out     = par_q;
  assign Short_shift = short_q;

  // OPC_BYPASS decodes through the default branch; kept for documentation.
  logic unused_bypass_opc;
  assign unused_bypass_opc = ^OPC_BYPASS;

endmodule
